// File: rtl/key_event_pkg.sv
// key_event_pkg: register map, control/status bit positions and event word layout
package key_event_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_REL_EN = 1;
    localparam int CTRL_FLUSH  = 2;
    localparam int STAT_OVF    = 16;
    localparam int STAT_EMPTY  = 17;
    localparam int TS_W        = 16;
    localparam int KEY_W       = 4;
    typedef struct packed {
        logic            valid;
        logic [2:0]      pad_hi;
        logic [TS_W-1:0] ts;
        logic [2:0]      pad_mid;
        logic            press;
        logic [3:0]      pad_lo;
        logic [KEY_W-1:0] key;
    } event_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizer, debounce counter, stable level and 1-deep pending flag for one key
// clk_i/rst_ni   clock, async active-low reset
// key_ni         raw active-low button
// clr_i          clears the pending flag (granted or flushed)
// ts_i           current timestamp, captured when the stable level changes
// pend_o         an event is waiting for the arbiter
// stable_o       debounced level (1 = released)
// ts_o           timestamp of the last stable change
module key_debounce
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            key_ni,
    input  logic            clr_i,
    input  logic [TS_W-1:0] ts_i,
    output logic            pend_o,
    output logic            stable_o,
    output logic [TS_W-1:0] ts_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic sync1_q, sync2_q, stable_q, stable_d, pend_q, pend_d, hit;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TS_W-1:0] ts_q, ts_d;
    always_comb begin
        hit      = (sync2_q != stable_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (sync2_q == stable_q || hit) ? '0 : cnt_q + 1'b1;
        stable_d = hit ? sync2_q : stable_q;
        ts_d     = hit ? ts_i : ts_q;
        // a fresh event wins over a clear arriving in the same cycle
        pend_d   = hit | (pend_q & ~clr_i);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            ts_q     <= '0;
        end else begin
            sync1_q  <= key_ni;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            ts_q     <= ts_d;
        end
    end
    assign pend_o   = pend_q;
    assign stable_o = stable_q;
    assign ts_o     = ts_q;
endmodule

// File: rtl/key_event_fifo.sv
// key_event_fifo: debounced key press/release event queue, Avalon-MM slave with level irq
// clk_clk/reset_reset_n  clock, async active-low reset
// key_n                  raw active-low buttons
// avs_*                  Avalon-MM slave, read latency 1 (DATA pops, STATUS, CTRL)
// irq                    irq_en & (fifo not empty | overflow), registered
// Optional: KEY_EVENT_TIMESTAMP_EN builds the TS_DIV prescaler and 16-bit timestamp
module key_event_fifo
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int FIFO_DEPTH      = 16,
    parameter int TS_DIV          = 50_000
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [1:0]          avs_address,
    input  logic                avs_read,
    input  logic                avs_write,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    output logic                irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [NUM_KEYS-1:0] pend, stable, grant, clr;
    logic [TS_W-1:0] key_ts [NUM_KEYS];
    logic [TS_W-1:0] ts_now, ev_ts;
    logic [KEY_W-1:0] sel;
    logic any, ev_press, push, push_ok, pop, full, empty, flush, ctrl_wr, stat_wr;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level;
    logic ovf_q, ovf_d, irq_en_q, irq_en_d, rel_en_q, rel_en_d, irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d, status, ctrl;
    event_t ev;
    event_t mem_q [FIFO_DEPTH];
    logic unused_wdata;
    assign unused_wdata = ^{avs_writedata[31:17], avs_writedata[15:3]};
`ifdef KEY_EVENT_TIMESTAMP_EN
    localparam int PW = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
    logic [PW-1:0] pre_q;
    logic [TS_W-1:0] ts_q;
    logic tick;
    assign tick = (pre_q == PW'(TS_DIV - 1));
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pre_q <= '0;
            ts_q  <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            ts_q  <= tick ? ts_q + 1'b1 : ts_q;
        end
    end
    assign ts_now = ts_q;
`else
    assign ts_now = '0;
`endif
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk_i   (clk_clk),
            .rst_ni  (reset_reset_n),
            .key_ni  (key_n[k]),
            .clr_i   (clr[k]),
            .ts_i    (ts_now),
            .pend_o  (pend[k]),
            .stable_o(stable[k]),
            .ts_o    (key_ts[k])
        );
    end
    // lowest-index pending key gets the single push slot
    always_comb begin
        any      = 1'b0;
        sel      = '0;
        grant    = '0;
        ev_ts    = '0;
        ev_press = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (pend[i] && !any) begin
                any      = 1'b1;
                sel      = KEY_W'(i);
                grant[i] = 1'b1;
                ev_ts    = key_ts[i];
                ev_press = ~stable[i];
            end
        end
        ev       = '0;
        ev.valid = 1'b1;
        ev.ts    = ev_ts;
        ev.press = ev_press;
        ev.key   = sel;
    end
    always_comb begin
        level    = wptr_q - rptr_q;
        empty    = (wptr_q == rptr_q);
        full     = (level == (AW+1)'(FIFO_DEPTH));
        ctrl_wr  = avs_write && avs_address == REG_CTRL;
        stat_wr  = avs_write && avs_address == REG_STATUS;
        flush    = ctrl_wr && avs_writedata[CTRL_FLUSH];
        clr      = grant | {NUM_KEYS{flush}};
        pop      = avs_read && avs_address == REG_DATA && !empty;
        push     = any && (rel_en_q || ev_press) && !flush;
        // a pop in the same cycle frees the slot for a push into a full queue
        push_ok  = push && (!full || pop);
        wptr_d   = flush ? '0 : wptr_q + (AW+1)'(push_ok);
        rptr_d   = flush ? '0 : rptr_q + (AW+1)'(pop);
        ovf_d    = (push && !push_ok) | (ovf_q & ~(stat_wr && avs_writedata[STAT_OVF]));
        irq_en_d = ctrl_wr ? avs_writedata[CTRL_IRQ_EN] : irq_en_q;
        rel_en_d = ctrl_wr ? avs_writedata[CTRL_REL_EN] : rel_en_q;
        irq_d    = irq_en_q & ((level != '0) | ovf_q);
        status   = {14'b0, empty, ovf_q, 16'(level)};
        ctrl     = {30'b0, rel_en_q, irq_en_q};
        rdata_d  = !avs_read ? '0 :
                   avs_address == REG_DATA   ? (empty ? '0 : 32'(mem_q[rptr_q[AW-1:0]])) :
                   avs_address == REG_STATUS ? status :
                   avs_address == REG_CTRL   ? ctrl : '0;
    end
    always_ff @(posedge clk_clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= ev;
    end
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            rel_en_q <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            rel_en_q <= rel_en_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end
    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
endmodule

// File: tb/tb_key_event_fifo.sv
// tb_key_event_fifo: directed table-driven bench for key_event_fifo (DEBOUNCE 16, depth 4)
module tb_key_event_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key_n = 4'hF;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    int nchk = 0;
    int nerr = 0;
`ifdef KEY_EVENT_TIMESTAMP_EN
    localparam logic [31:0] EXP6 = 32'h8000_4102;
`else
    localparam logic [31:0] EXP6 = 32'h8000_0102;
`endif
    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vr[4];
    vec_t v3[8];

    key_event_fifo #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(16), .FIFO_DEPTH(4), .TS_DIV(4)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .key_n        (key_n),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_write = 1'b1;
        avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
        avs_writedata = '0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic run(input vec_t v);
        if (v.wr) wr(v.addr, v.wdata);
        else rd_chk(v.addr, v.exp, v.name);
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vr[0] = '{1'b0, 2'd1, 32'h0, 32'h0002_0000, "rst_status"};
        vr[1] = '{1'b0, 2'd2, 32'h0, 32'h0000_0000, "rst_ctrl"};
        vr[2] = '{1'b0, 2'd0, 32'h0, 32'h0000_0000, "rst_data"};
        vr[3] = '{1'b0, 2'd3, 32'h0, 32'h0000_0000, "rst_reg3"};
        v3[0] = '{1'b0, 2'd1, 32'h0, 32'h0001_0004, "t3_status_full_ovf"};
        v3[1] = '{1'b0, 2'd0, 32'h0, 32'h8000_0102, "t3_data0"};
        v3[2] = '{1'b0, 2'd0, 32'h0, 32'h8000_0002, "t3_data1"};
        v3[3] = '{1'b0, 2'd0, 32'h0, 32'h8000_0102, "t3_data2"};
        v3[4] = '{1'b0, 2'd0, 32'h0, 32'h8000_0002, "t3_data3"};
        v3[5] = '{1'b0, 2'd1, 32'h0, 32'h0003_0000, "t3_status_empty_ovf"};
        v3[6] = '{1'b1, 2'd1, 32'h0001_0000, 32'h0, "t3_clr_ovf"};
        v3[7] = '{1'b0, 2'd1, 32'h0, 32'h0002_0000, "t3_status_clr"};

        waitn(3);
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        waitn(2);
        for (int i = 0; i < 4; i++) run(vr[i]);
        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk(2'd3, 32'h0, "reg3_after_write");

        // 1: KEY1 press, level/irq timing, read-pop
        wr(2'd2, 32'h1);
        key_n[1] = 1'b0;
        waitn(19);
        check("t1_irq_edge18", {31'b0, irq}, 32'h0);
        waitn(1);
        check("t1_irq_edge19", {31'b0, irq}, 32'h1);
        key_n[1] = 1'b1;
        waitn(40);
        rd_chk(2'd1, 32'h0000_0001, "t1_level");
        rd_chk(2'd0, 32'h8000_0101, "t1_data");
        rd_chk(2'd0, 32'h0000_0000, "t1_data_empty");
        rd_chk(2'd1, 32'h0002_0000, "t1_status_empty");

        // 2: glitch shorter than debounce
        key_n[0] = 1'b0;
        waitn(10);
        key_n[0] = 1'b1;
        waitn(40);
        rd_chk(2'd1, 32'h0002_0000, "t2_no_event");

        // 3: overflow with release events enabled
        wr(2'd2, 32'h2);
        for (int p = 0; p < 5; p++) begin
            key_n[2] = 1'b0;
            waitn(20);
            key_n[2] = 1'b1;
            waitn(20);
        end
        waitn(10);
        for (int i = 0; i < 8; i++) run(v3[i]);

        // 4: simultaneous keys, back-to-back reads, flush
        key_n[0] = 1'b0;
        key_n[3] = 1'b0;
        waitn(30);
        rd_chk(2'd1, 32'h0000_0002, "t4_level2");
        @(negedge clk);
        avs_address = 2'd0;
        avs_read = 1'b1;
        @(negedge clk);
        check("t4_b2b_0", avs_readdata, 32'h8000_0100);
        @(negedge clk);
        avs_read = 1'b0;
        check("t4_b2b_1", avs_readdata, 32'h8000_0103);
        key_n[0] = 1'b1;
        key_n[3] = 1'b1;
        waitn(30);
        rd_chk(2'd1, 32'h0000_0002, "t4_releases");
        wr(2'd2, 32'h6);
        rd_chk(2'd2, 32'h0000_0002, "t4_ctrl_flush_reads0");
        rd_chk(2'd1, 32'h0002_0000, "t4_flushed");

        // 5: release discarded, irq until read
        wr(2'd2, 32'h1);
        key_n[1] = 1'b0;
        waitn(20);
        key_n[1] = 1'b1;
        waitn(40);
        rd_chk(2'd1, 32'h0000_0001, "t5_one_entry");
        check("t5_irq_set", {31'b0, irq}, 32'h1);
        rd_chk(2'd0, 32'h8000_0101, "t5_data");
        check("t5_irq_at_pop", {31'b0, irq}, 32'h1);
        waitn(1);
        check("t5_irq_clear", {31'b0, irq}, 32'h0);

        // 6: reset mid-operation with KEY2 held
        wr(2'd2, 32'h3);
        key_n[0] = 1'b0;
        waitn(20);
        key_n[0] = 1'b1;
        waitn(30);
        rd_chk(2'd1, 32'h0000_0002, "t6_two_queued");
        check("t6_irq_before", {31'b0, irq}, 32'h1);
        key_n[2] = 1'b0;
        waitn(5);
        rst_n = 1'b0;
        waitn(1);
        check("t6_irq_in_reset", {31'b0, irq}, 32'h0);
        check("t6_rdata_in_reset", avs_readdata, 32'h0);
        waitn(1);
        rst_n = 1'b1;
        waitn(17);
        rd_chk(2'd1, 32'h0002_0000, "t6_edge18_empty");
        rd_chk(2'd1, 32'h0000_0001, "t6_after_push");
        check("t6_irq_after", {31'b0, irq}, 32'h0);
        rd_chk(2'd0, EXP6, "t6_press_entry");
        key_n[2] = 1'b1;
        waitn(5);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
